// File: rtl/calc_pkg.sv
// Shared widths, default job timeout and FSM state encoding for the calc arbiter.
package calc_pkg;

  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StRun,
    StDone,
    StAbort
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   pick = 2'b01;
        2'b10:   pick = 2'b10;
        2'b11:   pick = last ? 2'b01 : 2'b10;
        default: pick = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one stack-machine controller between two requesters: grants, forwards program
// writes, launches the job, then reports completion or aborts it on timeout.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [1:0]        wr_in,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [1:0]        start_in,
  output logic              ctl_wr,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_datain,
  output logic              ctl_start,
  input  logic              ctl_ready,
  input  logic [DATA_W-1:0] ctl_out,
  output logic              ctl_nrst,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;

  state_e              r_state;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic [1:0]          r_err;
  logic [DATA_W-1:0]   r_result;
  logic                r_last;
  logic [TimerW-1:0]   r_timer;
  logic                r_busy_seen;
  logic                r_abort_cnt;

  logic [1:0]          w_pick;
  logic                w_arb_en;
  logic                w_gidx;

  assign w_arb_en = (r_state == StIdle) && ctl_ready;
  assign w_gidx   = r_gnt[1];

  rr_arb2 u_rr (
    .req    (req),
    .last   (r_last),
    .enable (w_arb_en),
    .pick   (w_pick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= StIdle;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 2'b00;
      r_result    <= '0;
      r_last      <= 1'b1;
      r_timer     <= '0;
      r_busy_seen <= 1'b0;
      r_abort_cnt <= 1'b0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      unique case (r_state)
        StIdle: begin
          if (w_pick != 2'b00) begin
            r_gnt   <= w_pick;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (start_in[w_gidx]) begin
            r_state <= StLaunch;
          end else if (!req[w_gidx]) begin
            r_state <= StIdle;
            r_gnt   <= 2'b00;
            r_last  <= w_gidx;
          end
        end
        StLaunch: begin
          r_state     <= StRun;
          r_timer     <= '0;
          r_busy_seen <= 1'b0;
        end
        StRun: begin
          r_timer <= r_timer + 1'b1;
          if (!ctl_ready) r_busy_seen <= 1'b1;
          // Ready only counts once the controller has been seen busy for this job.
          if (ctl_ready && r_busy_seen) begin
            r_result <= ctl_out;
            r_done   <= r_gnt;
            r_state  <= StDone;
          end else if (r_timer == TimerW'(TIMEOUT - 1)) begin
            r_err       <= r_gnt;
            r_abort_cnt <= 1'b0;
            r_state     <= StAbort;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_gnt   <= 2'b00;
          r_last  <= w_gidx;
        end
        StAbort: begin
          r_abort_cnt <= 1'b1;
          if (r_abort_cnt) begin
            r_state <= StIdle;
            r_gnt   <= 2'b00;
            r_last  <= w_gidx;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ctl_wr     = (r_state == StLoad) && wr_in[w_gidx];
  assign ctl_addr   = w_gidx ? addr1 : addr0;
  assign ctl_datain = w_gidx ? data1 : data0;
  assign ctl_start  = (r_state == StLaunch);
  assign ctl_nrst   = nrst && (r_state != StAbort);

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_calc_arbiter.sv
// Scoreboarded random bench for calc_arbiter with a simple stack-machine controller stub.
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        nrst;
  logic [1:0]  req, gnt, wr_in, start_in, done, err;
  logic [9:0]  addr0, addr1, ctl_addr;
  logic [15:0] data0, data1, ctl_datain, ctl_out, result;
  logic        ctl_wr, ctl_start, ctl_ready, ctl_nrst;

  calc_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .gnt        (gnt),
    .wr_in      (wr_in),
    .addr0      (addr0),
    .addr1      (addr1),
    .data0      (data0),
    .data1      (data1),
    .start_in   (start_in),
    .ctl_wr     (ctl_wr),
    .ctl_addr   (ctl_addr),
    .ctl_datain (ctl_datain),
    .ctl_start  (ctl_start),
    .ctl_ready  (ctl_ready),
    .ctl_out    (ctl_out),
    .ctl_nrst   (ctl_nrst),
    .done       (done),
    .err        (err),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller stub: 00=push imm14, 01=add, 10=jump, 11=halt; one instruction per cycle.
  logic [15:0] c_mem [1024];
  logic [15:0] c_stk [16];
  logic [3:0]  c_sp;
  logic [9:0]  c_pc;
  logic        c_ready;
  logic [15:0] c_out;
  logic [15:0] c_ins;

  initial for (int i = 0; i < 1024; i++) c_mem[i] = 16'h0;

  assign c_ins     = c_mem[c_pc];
  assign ctl_ready = c_ready;
  assign ctl_out   = c_out;

  always @(posedge clk) begin
    if (!ctl_nrst) begin
      c_ready <= 1'b1;
      c_sp    <= 4'd0;
      c_pc    <= 10'd0;
      c_out   <= 16'h0;
    end else begin
      if (ctl_wr) c_mem[ctl_addr] <= ctl_datain;
      if (ctl_start) begin
        c_ready <= 1'b0;
        c_pc    <= 10'd0;
        c_sp    <= 4'd0;
      end else if (!c_ready) begin
        case (c_ins[15:14])
          2'b00: begin
            c_stk[c_sp] <= {2'b00, c_ins[13:0]};
            c_sp        <= c_sp + 4'd1;
            c_pc        <= c_pc + 10'd1;
          end
          2'b01: begin
            c_stk[c_sp-4'd2] <= c_stk[c_sp-4'd2] + c_stk[c_sp-4'd1];
            c_sp             <= c_sp - 4'd1;
            c_pc             <= c_pc + 10'd1;
          end
          2'b10: c_pc <= c_ins[9:0];
          default: begin
            c_ready <= 1'b1;
            c_out   <= (c_sp != 4'd0) ? c_stk[c_sp-4'd1] : 16'h0;
          end
        endcase
      end
    end
  end

  // Reference model: program interpreter plus round-robin and result bookkeeping.
  typedef struct packed {
    logic        is_err;
    logic [1:0]  who;
    logic [15:0] res;
  } ev_t;

  ev_t         ev_q[$];
  logic [1:0]  gnt_q[$];
  logic        m_last;
  logic [15:0] m_result;

  function automatic logic [16:0] eval_prog(input logic [15:0] p[$]);
    logic [15:0] stk[$];
    logic [15:0] a, b, ins;
    int pc = 0;
    for (int step = 0; step < int'(TO) - 2; step++) begin
      if (pc >= p.size()) return 17'h0;
      ins = p[pc];
      case (ins[15:14])
        2'b00: begin stk.push_back({2'b00, ins[13:0]}); pc++; end
        2'b01: begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a + b); pc++; end
        2'b10: pc = int'(ins[9:0]);
        default: return {1'b1, (stk.size() > 0) ? stk[$] : 16'h0};
      endcase
    end
    return 17'h0;
  endfunction

  task automatic gen_prog(output logic [15:0] p[$]);
    int depth = 0;
    int n = $urandom_range(1, 6);
    p = {};
    for (int i = 0; i < n; i++) begin
      if (depth >= 2 && ($urandom % 3) == 0) begin
        p.push_back(16'h4000);
        depth--;
      end else begin
        p.push_back({2'b00, 14'($urandom)});
        depth++;
      end
    end
    p.push_back(16'hC000);
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or pulses done/err.
  logic [1:0] prev_gnt = 2'b00;
  int         start_cyc = 0;
  int         lowcnt = 0;
  ev_t        mon_e;

  always @(negedge clk) begin
    #1;
    if (nrst) begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'h0);
        else chk("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
      end
      if (ctl_start) start_cyc = cyc;
      if (done != 2'b00 || err != 2'b00) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {28'h0, done, err}, 32'h0);
        end else begin
          mon_e = ev_q.pop_front();
          if (mon_e.is_err) begin
            chk("err_who", 32'(err), 32'(mon_e.who));
            chk("no_done_on_abort", 32'(done), 32'h0);
            chk("err_latency", 32'(cyc - start_cyc), 32'(TO + 1));
          end else begin
            chk("done_who", 32'(done), 32'(mon_e.who));
            chk("no_err_on_done", 32'(err), 32'h0);
          end
          chk("result", 32'(result), 32'(mon_e.res));
        end
      end
      if (!ctl_nrst) lowcnt++;
      else if (lowcnt != 0) begin
        chk("ctl_nrst_low_cycles", 32'(lowcnt), 32'd2);
        lowcnt = 0;
      end
    end else begin
      lowcnt = 0;
    end
    prev_gnt = gnt;
  end

  task automatic drive_wr(input int who, input logic [9:0] a, input logic [15:0] d);
    wr_in[who] = 1'b1;
    if (who == 0) begin addr0 = a; data0 = d; end
    else begin addr1 = a; data1 = d; end
  endtask

  // mode: 0 = run to completion/abort, 1 = drop req in LOAD, 2 = reset during RUN.
  task automatic run_job(input logic [1:0] reqv, input logic [15:0] prog[$], input int mode,
                         input bit junk);
    int w, o;
    bit ok, comb_start;
    logic [16:0] ev;
    logic [9:0] jaddr[$];
    ev_t e;
    w = (reqv == 2'b11) ? int'(!m_last) : (reqv[1] ? 1 : 0);
    o = 1 - w;
    comb_start = (mode != 1) && ($urandom % 2 == 1);
    req = reqv;
    gnt_q.push_back(2'(1 << w));
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin ok = 1; break; end
    end
    if (!ok) begin chk("gnt_timeout", 32'h0, 32'h1); req = 2'b00; return; end
    if ($urandom % 2 == 1) begin
      start_in[o] = 1'b1;
      @(negedge clk);
      start_in = 2'b00;
    end
    for (int i = 0; i < prog.size(); i++) begin
      if (junk && ($urandom % 2 == 1)) begin
        jaddr.push_back(10'(512 + $urandom_range(0, 511)));
        drive_wr(o, jaddr[$], 16'hBEEF);
        #1 chk("ctl_wr_masked", 32'(ctl_wr), 32'h0);
        @(negedge clk);
        wr_in = 2'b00;
      end
      drive_wr(w, 10'(i), prog[i]);
      if (comb_start && i == prog.size() - 1) start_in[w] = 1'b1;
      #1;
      chk("ctl_wr", 32'(ctl_wr), 32'h1);
      chk("ctl_addr", 32'(ctl_addr), 32'(i));
      chk("ctl_datain", 32'(ctl_datain), 32'(prog[i]));
      @(negedge clk);
      wr_in = 2'b00;
    end
    start_in = 2'b00;
    if (mode == 1) begin
      req = 2'b00;
      @(negedge clk);
      #1 chk("drop_gnt", 32'(gnt), 32'h0);
      m_last = w[0];
      return;
    end
    if (mode == 0) begin
      ev = eval_prog(prog);
      e.who = 2'(1 << w);
      e.is_err = !ev[16];
      e.res = ev[16] ? ev[15:0] : m_result;
      ev_q.push_back(e);
      if (ev[16]) m_result = ev[15:0];
    end
    if (!comb_start) begin
      start_in[w] = 1'b1;
      @(negedge clk);
      start_in = 2'b00;
    end
    if (mode == 2) begin
      repeat (5) @(negedge clk);
      chk("pre_reset_result", 32'(result), 32'(m_result));
      nrst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_ctl_nrst", 32'(ctl_nrst), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      repeat (2) @(negedge clk);
      req = 2'b00;
      nrst = 1'b1;
      m_last = 1'b1;
      m_result = 16'h0;
      repeat (10) @(negedge clk);
      return;
    end
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done != 2'b00 || err != 2'b00) begin ok = 1; break; end
    end
    if (!ok) chk("job_end_timeout", 32'h0, 32'h1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt == 2'b00) begin ok = 1; break; end
    end
    if (!ok) chk("gnt_release_timeout", 32'h0, 32'h1);
    m_last = w[0];
    foreach (jaddr[k]) chk("junk_mem", 32'(c_mem[jaddr[k]]), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [15:0] p[$];
  logic [1:0]  reqv;
  int          r;

  initial begin
    req = 2'b00; wr_in = 2'b00; start_in = 2'b00;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    nrst = 1'b0;
    m_last = 1'b1;
    m_result = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_ctl_nrst", 32'(ctl_nrst), 32'h0);
    chk("reset_ctl_start", 32'(ctl_start), 32'h0);
    @(negedge clk);
    nrst = 1'b1;

    p = {16'h0002, 16'h0003, 16'hC000};
    run_job(2'b11, p, 0, 0);
    gen_prog(p);
    run_job(2'b11, p, 0, 0);
    gen_prog(p);
    run_job(2'b01, p, 0, 1);
    p = {16'h8000};
    run_job(2'b01, p, 0, 0);
    gen_prog(p);
    run_job(2'b01, p, 1, 0);

    repeat (14) begin
      r = $urandom_range(0, 9);
      reqv = 2'($urandom_range(1, 3));
      if (r < 2) p = {16'h8000};
      else gen_prog(p);
      run_job(reqv, p, (r == 9) ? 1 : 0, ($urandom % 2) == 1);
    end

    p = {16'h0005, 16'hC000};
    run_job(2'b10, p, 0, 0);
    p = {16'h8000};
    run_job(2'b01, p, 2, 0);

    repeat (5) @(negedge clk);
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    chk("ev_q_empty", 32'(ev_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
